// File: rtl/fetch_pc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_ctrl_if
// Description : Signal bundle between the fetch PC controller and its
//               surroundings (BTB read/write ports, decode stall, EX-stage
//               branch resolution, instruction-memory fetch address and
//               performance counters).
//   master modport : the PC controller itself
//     in  stall                         decode hazard stall
//     in  btb_valid/btb_taken/btb_target BTB lookup result for current pc
//     in  ex_branch/ex_taken/ex_target  branch resolution from EX
//     out pc                            current fetch PC
//     out flush                         squash IF/ID and ID/EX
//     out btb_update/btb_mispredicted   BTB write enable / mispredict flag
//     out btb_update_pc/btb_update_target BTB write address / target
//     out branch_count/mispredict_count performance counters
//   slave modport  : the environment (mirror directions)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_ctrl_if;

  // Pipeline control and BTB lookup
  logic        stall;
  logic        btb_valid;
  logic        btb_taken;
  logic [31:0] btb_target;

  // Branch resolution from the EX stage
  logic        ex_branch;
  logic        ex_taken;
  logic [31:0] ex_target;

  // Fetch address and squash
  logic [31:0] pc;
  logic        flush;

  // BTB write port
  logic        btb_update;
  logic        btb_mispredicted;
  logic [31:0] btb_update_pc;
  logic [31:0] btb_update_target;

  // Performance counters
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    input  stall, btb_valid, btb_taken, btb_target,
    input  ex_branch, ex_taken, ex_target,
    output pc, flush,
    output btb_update, btb_mispredicted, btb_update_pc, btb_update_target,
    output branch_count, mispredict_count
  );

  modport slave (
    output stall, btb_valid, btb_taken, btb_target,
    output ex_branch, ex_taken, ex_target,
    input  pc, flush,
    input  btb_update, btb_mispredicted, btb_update_pc, btb_update_target,
    input  branch_count, mispredict_count
  );

endinterface : fetch_pc_ctrl_if
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_ctrl
// Description : Fetch program-counter controller with BTB-driven next-PC
//               prediction and EX-stage misprediction recovery.
//               The prediction made for each fetched instruction travels
//               alongside it through ID and EX so that EX can compare the
//               actual outcome against what fetch assumed.
// Ports       :
//   clk    in   single clock, rising edge
//   rst    in   asynchronous active-low reset
//   bus    ---  fetch_pc_ctrl_if.master (see interface header)
// Parameters  :
//   RESET_PC   PC value loaded while reset is asserted
// Build macro :
//   PERF_COUNTERS_EN  when defined, branch_count / mispredict_count are
//                     free-running 32-bit counters; otherwise both ports
//                     are tied to zero and no counter flops exist.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire             clk,
  input  wire             rst,
  fetch_pc_ctrl_if.master bus
);

  // --------------------------------------------------------------------------
  // Prediction entry carried with each instruction through ID and EX
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic        v;            // entry holds a real instruction
    logic [31:0] pc;           // fetch address of that instruction
    logic        pred_taken;   // fetch redirected to pred_target
    logic [31:0] pred_target;  // address fetch continued from if taken
  } pred_entry_t;

  localparam pred_entry_t c_bubble = '0;
  localparam logic [31:0] c_inst_bytes = 32'd4;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0] r_pc;
  pred_entry_t r_id;
  pred_entry_t r_ex;

  // --------------------------------------------------------------------------
  // Combinational decode of the current cycle
  // --------------------------------------------------------------------------
  logic        w_pred_hit;
  pred_entry_t w_if_entry;
  logic        w_eff_taken;
  logic        w_dir_wrong;
  logic        w_tgt_wrong;
  logic        w_mispredict;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;

  // Only a taken BTB hit steers fetch; a not-taken hit falls through.
  assign w_pred_hit = bus.btb_valid & bus.btb_taken;

  assign w_if_entry.v           = 1'b1;
  assign w_if_entry.pc          = r_pc;
  assign w_if_entry.pred_taken  = w_pred_hit;
  assign w_if_entry.pred_target = bus.btb_target;

  // A bubble in EX counts as "predicted not-taken": if a branch nevertheless
  // resolves there, a taken outcome must redirect while a not-taken one is
  // already on the correct sequential path.
  assign w_eff_taken = r_ex.v & r_ex.pred_taken;

  // Direction wrong, or direction right (taken) but the target differs.
  assign w_dir_wrong  = bus.ex_taken != w_eff_taken;
  assign w_tgt_wrong  = bus.ex_taken & (bus.ex_target != r_ex.pred_target);
  assign w_mispredict = bus.ex_branch & (w_dir_wrong | w_tgt_wrong);

  // Recovery address: the real target, or the fall-through of the branch.
  // 32-bit adds wrap naturally (0xFFFF_FFFC + 4 = 0).
  assign w_pc_plus4    = r_pc + c_inst_bytes;
  assign w_redirect_pc = bus.ex_taken ? bus.ex_target
                                      : (r_ex.pc + c_inst_bytes);

  // Next-PC priority: redirect > stall > BTB prediction > sequential.
  // The redirect deliberately overrides a stall: the stalled instruction in
  // ID is on the wrong path and is being squashed anyway.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (w_mispredict) begin
      w_next_pc = w_redirect_pc;
    end else if (bus.stall) begin
      w_next_pc = r_pc;
    end else if (w_pred_hit) begin
      w_next_pc = bus.btb_target;
    end
  end

  // --------------------------------------------------------------------------
  // PC register and prediction pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
      r_id <= c_bubble;
      r_ex <= c_bubble;
    end else begin
      r_pc <= w_next_pc;
      if (w_mispredict) begin
        // Both younger entries are on the wrong path.
        r_id <= c_bubble;
        r_ex <= c_bubble;
      end else if (bus.stall) begin
        // ID waits for the hazard to clear; EX receives a bubble.
        r_id <= r_id;
        r_ex <= c_bubble;
      end else begin
        r_id <= w_if_entry;
        r_ex <= r_id;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.pc    = r_pc;
  assign bus.flush = w_mispredict;

  // Every resolving branch trains the BTB. Address and target are forced to
  // zero when no update is requested so the write port is quiet when idle.
  assign bus.btb_update        = bus.ex_branch;
  assign bus.btb_mispredicted  = w_mispredict;
  assign bus.btb_update_pc     = bus.ex_branch ? r_ex.pc       : 32'h0;
  assign bus.btb_update_target = bus.ex_branch ? bus.ex_target : 32'h0;

  // --------------------------------------------------------------------------
  // Performance counters (optional)
  // --------------------------------------------------------------------------
`ifdef PERF_COUNTERS_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  // Both counters wrap modulo 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_branch_count     <= 32'h0;
      r_mispredict_count <= 32'h0;
    end else begin
      if (bus.ex_branch) begin
        r_branch_count <= r_branch_count + 32'd1;
      end
      if (w_mispredict) begin
        r_mispredict_count <= r_mispredict_count + 32'd1;
      end
    end
  end

  assign bus.branch_count     = r_branch_count;
  assign bus.mispredict_count = r_mispredict_count;
`else
  assign bus.branch_count     = 32'h0;
  assign bus.mispredict_count = 32'h0;
`endif

endmodule : fetch_pc_ctrl
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_ctrl
// Description : Self-checking bench for fetch_pc_ctrl. A behavioural model
//               of fetch (PC plus the predictions of the two instructions in
//               flight) is compared against the DUT on every falling edge;
//               directed scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  fetch_pc_ctrl_if bus();

  fetch_pc_ctrl #(.RESET_PC(RESET_PC)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: what fetch believes about each in-flight instruction
  // --------------------------------------------------------------------------
  typedef struct {
    bit        v;
    bit [31:0] pc;
    bit        pt;
    bit [31:0] tgt;
  } ent_t;

  bit [31:0] m_pc = RESET_PC;
  ent_t      m_id = '{v: 0, pc: 0, pt: 0, tgt: 0};
  ent_t      m_ex = '{v: 0, pc: 0, pt: 0, tgt: 0};
  bit [31:0] m_bc = 0;
  bit [31:0] m_mc = 0;

  // Was the instruction now resolving in EX fetched down the wrong path?
  function automatic bit model_wrong_path();
    bit assumed_taken;
    assumed_taken = m_ex.v && m_ex.pt;
    if (!bus.ex_branch) return 0;
    if (bus.ex_taken != assumed_taken) return 1;
    return bus.ex_taken && (bus.ex_target != m_ex.tgt);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = RESET_PC;
      m_id = '{v: 0, pc: 0, pt: 0, tgt: 0};
      m_ex = '{v: 0, pc: 0, pt: 0, tgt: 0};
      m_bc = 0;
      m_mc = 0;
    end else begin
      bit wrong;
      bit hit;
      wrong = model_wrong_path();
      hit   = bus.btb_valid && bus.btb_taken;
`ifdef PERF_COUNTERS_EN
      if (bus.ex_branch) m_bc = m_bc + 1;
      if (wrong)         m_mc = m_mc + 1;
`endif
      if (wrong) begin
        m_pc = bus.ex_taken ? bus.ex_target : m_ex.pc + 32'd4;
        m_id.v = 0;
        m_ex.v = 0;
      end else if (bus.stall) begin
        m_ex.v = 0;
      end else begin
        m_ex = m_id;
        m_id = '{v: 1, pc: m_pc, pt: hit, tgt: bus.btb_target};
        m_pc = hit ? bus.btb_target : m_pc + 32'd4;
      end
    end
  end

  // One compare process, every cycle, away from the active edge.
  always @(negedge clk) begin
    bit wrong;
    wrong = model_wrong_path();
    chk("model_pc", bus.pc, m_pc);
    chk("model_flush", 32'(bus.flush), 32'(wrong));
    chk("model_btb_update", 32'(bus.btb_update), 32'(bus.ex_branch));
    chk("model_btb_mispredicted", 32'(bus.btb_mispredicted), 32'(wrong));
    if (bus.ex_branch && m_ex.v) begin
      chk("model_btb_update_pc", bus.btb_update_pc, m_ex.pc);
      chk("model_btb_update_target", bus.btb_update_target, bus.ex_target);
    end
    chk("model_branch_count", bus.branch_count, m_bc);
    chk("model_mispredict_count", bus.mispredict_count, m_mc);
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic idle();
    bus.stall      = 1'b0;
    bus.btb_valid  = 1'b0;
    bus.btb_taken  = 1'b0;
    bus.btb_target = 32'h0;
    bus.ex_branch  = 1'b0;
    bus.ex_taken   = 1'b0;
    bus.ex_target  = 32'h0;
  endtask

  task automatic btb(input logic [31:0] t);
    bus.btb_valid  = 1'b1;
    bus.btb_taken  = 1'b1;
    bus.btb_target = t;
  endtask

  task automatic exr(input logic taken, input logic [31:0] t);
    bus.ex_branch = 1'b1;
    bus.ex_taken  = taken;
    bus.ex_target = t;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", bus.pc, RESET_PC);
    rst = 1'b1;

    // Sequential fetch 0,4,8,C; stall asserted from pc=C.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.stall = 1'b1;
      @(negedge clk);
      chk("seq_pc", bus.pc, 32'(i * 4));
      if (i == 0) begin
        chk("post_reset_flush", 32'(bus.flush), 32'h0);
        chk("post_reset_btb_update", 32'(bus.btb_update), 32'h0);
        chk("post_reset_btb_update_pc", bus.btb_update_pc, 32'h0);
        chk("post_reset_btb_mispredicted", 32'(bus.btb_mispredicted), 32'h0);
      end
      next_cycle();
    end
    // Second stall cycle; not-taken branch resolves against the EX bubble.
    bus.stall = 1'b1;
    exr(1'b0, 32'h200);
    @(negedge clk);
    chk("stall_hold_pc", bus.pc, 32'h0000_000C);
    chk("bubble_nt_flush", 32'(bus.flush), 32'h0);
    chk("bubble_nt_btb_update", 32'(bus.btb_update), 32'h1);
    next_cycle();
    @(negedge clk);
    chk("stall_hold_pc2", bus.pc, 32'h0000_000C);
    next_cycle();
    // Taken branch against a not-predicted entry, then reset before the edge.
    exr(1'b1, 32'h100);
    @(negedge clk);
    chk("pre_reset_pc", bus.pc, 32'h0000_0010);
    chk("pre_reset_flush", 32'(bus.flush), 32'h1);
    #2;
    rst = 1'b0;
    idle();
    @(posedge clk);
    #1;
    chk("reset_discards_redirect", bus.pc, RESET_PC);
    rst = 1'b1;
    @(negedge clk);
    chk("first_fetch_after_reset", bus.pc, RESET_PC);
    next_cycle();                                   // pc = 4
    next_cycle();                                   // pc = 8
    btb(32'h40);
    @(negedge clk);
    chk("pred_at_8_pc", bus.pc, 32'h8);
    next_cycle();
    @(negedge clk);
    chk("pred_latency_pc", bus.pc, 32'h40);
    next_cycle();
    exr(1'b1, 32'h40);                              // correct prediction
    @(negedge clk);
    chk("correct_pc", bus.pc, 32'h44);
    chk("correct_flush", 32'(bus.flush), 32'h0);
    chk("correct_btb_update", 32'(bus.btb_update), 32'h1);
    chk("correct_btb_mispredicted", 32'(bus.btb_mispredicted), 32'h0);
    chk("correct_btb_update_pc", bus.btb_update_pc, 32'h8);
    next_cycle();
    btb(32'h10);                                    // steer fetch to 0x10
    next_cycle();
    @(negedge clk);
    chk("steer_pc", bus.pc, 32'h10);
    next_cycle();                                   // pc = 0x14
    next_cycle();                                   // pc = 0x18
    exr(1'b1, 32'h80);                              // unpredicted taken
    @(negedge clk);
    chk("nt_pred_flush", 32'(bus.flush), 32'h1);
    chk("nt_pred_btb_update_pc", bus.btb_update_pc, 32'h10);
    chk("nt_pred_btb_update_target", bus.btb_update_target, 32'h80);
    chk("nt_pred_btb_mispredicted", 32'(bus.btb_mispredicted), 32'h1);
    next_cycle();
    btb(32'h20);
    @(negedge clk);
    chk("redirect_taken_pc", bus.pc, 32'h80);
    next_cycle();
    btb(32'h60);                                    // predicted taken at 0x20
    @(negedge clk);
    chk("pred_at_20_pc", bus.pc, 32'h20);
    next_cycle();                                   // pc = 0x60
    next_cycle();                                   // pc = 0x64
    bus.stall = 1'b1;
    exr(1'b0, 32'h64);                              // resolves not-taken
    @(negedge clk);
    chk("t_pred_nt_flush", 32'(bus.flush), 32'h1);
    chk("t_pred_nt_btb_update_pc", bus.btb_update_pc, 32'h20);
    next_cycle();
    btb(32'h50);
    @(negedge clk);
    chk("redirect_beats_stall_pc", bus.pc, 32'h24);
`ifdef PERF_COUNTERS_EN
    chk("branch_count", bus.branch_count, 32'd3);
    chk("mispredict_count", bus.mispredict_count, 32'd2);
`else
    chk("branch_count", bus.branch_count, 32'd0);
    chk("mispredict_count", bus.mispredict_count, 32'd0);
`endif
    next_cycle();
    exr(1'b1, 32'h90);                              // flushes predicted 0x24
    @(negedge clk);
    chk("flush2_flush", 32'(bus.flush), 32'h1);
    next_cycle();
    exr(1'b0, 32'h0);                               // EX must be a bubble now
    btb(32'hFFFF_FFFC);
    @(negedge clk);
    chk("flushed_entry_gone", 32'(bus.flush), 32'h0);
    chk("flush2_pc", bus.pc, 32'h90);
    next_cycle();
    @(negedge clk);
    chk("top_pc", bus.pc, 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk);
    chk("wrap_pc", bus.pc, 32'h0);
    repeat (3) next_cycle();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fetch_pc_ctrl
`default_nettype wire

// File: doc/fetch_pc_ctrl.md
FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  decode hazard stall; holds the fetch PC and the IF->ID prediction entry.
REQ-005 btb_valid / btb_taken  input  1 each  BTB hit and predicted-taken flag for the current pc.
REQ-006 btb_target  input  32  BTB predicted target for the current pc.
REQ-007 ex_branch  input  1  the EX-stage instruction is a branch or jump resolving this cycle.
REQ-008 ex_taken  input  1  actual branch outcome in EX.
REQ-009 ex_target  input  32  actual taken target computed in EX.
REQ-010 pc  output  32  current fetch PC; drives the BTB read port and instruction memory.
REQ-011 flush  output  1  squash IF/ID and ID/EX; high in the mispredict cycle.
REQ-012 btb_update / btb_mispredicted  output  1 each  BTB write enable and mispredict flag.
REQ-013 btb_update_pc / btb_update_target  output  32 each  BTB write address and target.
REQ-014 branch_count / mispredict_count  output  32 each  performance counters.

Function
REQ-015 The block SHALL use pred_hit = btb_valid & btb_taken.
REQ-016 The next PC priority SHALL be: mispredict redirect > stall (hold pc) > pred_hit (btb_target) > pc+4.
REQ-017 A 2-entry prediction pipeline (ID, EX) SHALL carry {v, pc, pred_taken, pred_target}; IF-stage contents are {1, pc, pred_hit, btb_target}.
REQ-018 With no stall and no flush, ID SHALL load the IF contents and EX SHALL load ID every cycle.
REQ-019 On stall without flush, pc and ID SHALL hold, and EX SHALL load a bubble (v=0).
REQ-020 In EX, eff_taken SHALL equal EX.v & EX.pred_taken; a bubble behaves as predicted not-taken.
REQ-021 mispredict SHALL equal ex_branch & (ex_taken != eff_taken | (ex_taken & ex_target != EX.pred_target)).
REQ-022 On mispredict, the next pc SHALL be ex_target if ex_taken, else EX.pc+4, applied at the next edge regardless of stall.
REQ-023 flush SHALL be combinational and equal mispredict; on the following edge, ID.v and EX.v SHALL clear to 0.
REQ-024 btb_update SHALL equal ex_branch; btb_update_pc = EX.pc; btb_update_target = ex_target; btb_mispredicted = mispredict; all combinational, same cycle.
REQ-025 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
REQ-026 pc SHALL change only on a clock edge (registered); only flush and the btb_* outputs are combinational.
REQ-027 Fetch latency SHALL be one cycle: a pred_hit in cycle N makes pc = btb_target in cycle N+1.

Reset
REQ-028 While rst=0, pc SHALL be RESET_PC, ID.v and EX.v SHALL be 0, and the counters SHALL be 0, all asynchronously.
REQ-029 After reset, all combinational outputs SHALL be 0 provided ex_branch=0.
REQ-030 Reset asserted mid-redirect SHALL discard the redirect; the first fetch after release is RESET_PC.

Configuration
REQ-031 With PERF_COUNTERS_EN defined, branch_count SHALL increment on ex_branch and mispredict_count on mispredict; both are 32-bit and wrap.
REQ-032 Without PERF_COUNTERS_EN, both counter ports SHALL remain present and tie to 32'h0, with no counter flops.

Verification
REQ-033 Reset release, btb_valid=0, no stall, 4 cycles -> pc sequence 0,4,8,C.
REQ-034 At pc=8: btb_valid=1, btb_taken=1, btb_target=40 -> next pc=40; two cycles later, ex_branch=1, ex_taken=1, ex_target=40 -> flush=0, btb_update=1, btb_mispredicted=0.
REQ-035 Not-predicted branch at pc=10 resolves taken to 80 -> flush=1, btb_update_pc=10, btb_mispredicted=1, next pc=80, ID.v=EX.v=0.
REQ-036 Predicted-taken at 20 (target 60) resolves not-taken, with stall=1 in the same cycle -> flush=1, next pc=24 (redirect beats stall).
REQ-037 stall=1 for 2 cycles at pc=C -> pc holds C, EX receives bubbles; a later ex_branch with ex_taken=0 against a bubble -> no mispredict.
REQ-038 With PERF_COUNTERS_EN, after REQ-034 to REQ-036 -> branch_count=3, mispredict_count=2; without it -> both 0.
